// File: rtl/homomorphic_multiply_stream.sv
// homomorphic_multiply_stream
// Streaming modular convolution of two ciphertexts of DIMENSION+1 entries.
// Operands are loaded over a valid/ready input (A entries, then B entries).
// Each B beat is folded into the accumulators as it arrives. The
// 2*DIMENSION+1 result entries are then drained over a valid/ready output.
// Optional feature macro: HM_RESCALE_EN. When defined, each output entry is
// round(t*x/q). When undefined, the raw entry mod q is output.
module homomorphic_multiply_stream #(
  parameter int PLAINTEXT_MODULUS  = 8,
  parameter int PLAINTEXT_WIDTH    = 3,
  parameter int CIPHERTEXT_MODULUS = 64,
  parameter int CIPHERTEXT_WIDTH   = 6,
  parameter int DIMENSION          = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [CIPHERTEXT_WIDTH-1:0]         in_entry,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CIPHERTEXT_WIDTH-1:0]         out_entry,
  output logic [$clog2(2*DIMENSION+1)-1:0]    out_index,
  output logic                                out_last,
  output logic                                busy
);

  localparam int CW = CIPHERTEXT_WIDTH;
  localparam int PW = PLAINTEXT_WIDTH;
  localparam int NA = DIMENSION + 1;
  localparam int NR = 2 * DIMENSION + 1;
  localparam int IW = $clog2(NR);

  localparam logic [1:0] LOAD_A = 2'd0;
  localparam logic [1:0] LOAD_B = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  // Truncating arithmetic is only exact mod q for power-of-two moduli.
  if (PLAINTEXT_MODULUS != (1 << PLAINTEXT_WIDTH) ||
      CIPHERTEXT_MODULUS != (1 << CIPHERTEXT_WIDTH)) begin : g_bad_moduli
    $error("homomorphic_multiply_stream: moduli must be 2**WIDTH");
  end

  logic [1:0]    state;
  logic [IW-1:0] cnt;
  logic [CW-1:0] a_q    [NA];
  logic [CW-1:0] acc_q  [NR];
  logic [CW-1:0] acc_nx [NR];
  logic [CW-1:0] acc_sel;
  logic [CW-1:0] entry_f;
  logic          in_fire;
  logic          out_fire;
  logic          last_ab;
  logic          last_k;
  logic          wipe;

  // Handshake and status decode
  always_comb begin
    in_ready  = (state == LOAD_A) || (state == LOAD_B);
    out_valid = (state == DRAIN);
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
    last_ab   = (cnt == IW'(DIMENSION));
    last_k    = (cnt == IW'(NR - 1));
    busy      = !((state == LOAD_A) && (cnt == '0));
    wipe      = clear || (out_fire && last_k);
  end

  // Next accumulator values for a B beat with index cnt: acc[i+cnt] += A[i]*b
  always_comb begin
    for (int unsigned k = 0; k < NR; k++) begin
      acc_nx[k] = acc_q[k];
      for (int unsigned i = 0; i < NA; i++) begin
        if (k >= i && (k - i) <= DIMENSION && cnt == IW'(k - i)) begin
          acc_nx[k] = acc_nx[k] + a_q[i] * in_entry;
        end
      end
    end
  end

  // Select the accumulator addressed by the drain index
  always_comb begin
    acc_sel = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (cnt == IW'(k)) acc_sel = acc_q[k];
    end
  end

`ifdef HM_RESCALE_EN
  logic [CW+PW:0] scaled;

  // BFV rescale: round(t*x/q) computed at CW+PW+1 bits
  always_comb begin
    scaled  = ({{(PW+1){1'b0}}, acc_sel} * (CW+PW+1)'(PLAINTEXT_MODULUS))
            + (CW+PW+1)'(CIPHERTEXT_MODULUS / 2);
    entry_f = CW'(scaled >> CW);
  end
`else
  // Raw tensor entry mod q
  always_comb begin
    entry_f = acc_sel;
  end
`endif

  // Output port drive, held at zero outside DRAIN
  always_comb begin
    out_entry = out_valid ? entry_f : '0;
    out_index = out_valid ? cnt : '0;
    out_last  = out_valid & last_k;
  end

  // Load/accumulate/drain sequencing; clear and the final drain beat both wipe state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
      cnt   <= '0;
      for (int unsigned i = 0; i < NA; i++) a_q[i] <= '0;
      for (int unsigned k = 0; k < NR; k++) acc_q[k] <= '0;
    end else if (wipe) begin
      state <= LOAD_A;
      cnt   <= '0;
      for (int unsigned i = 0; i < NA; i++) a_q[i] <= '0;
      for (int unsigned k = 0; k < NR; k++) acc_q[k] <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_fire) begin
            for (int unsigned i = 0; i < NA; i++) begin
              if (cnt == IW'(i)) a_q[i] <= in_entry;
            end
            if (last_ab) begin
              cnt   <= '0;
              state <= LOAD_B;
            end else begin
              cnt <= cnt + IW'(1);
            end
          end
        end
        LOAD_B: begin
          if (in_fire) begin
            for (int unsigned k = 0; k < NR; k++) acc_q[k] <= acc_nx[k];
            if (last_ab) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + IW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_fire) cnt <= cnt + IW'(1);
        end
        default: begin
          state <= LOAD_A;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_homomorphic_multiply_stream.sv
// Self-checking bench for homomorphic_multiply_stream (default parameters).
// Expected results come from a direct convolution model over integers.
module tb_homomorphic_multiply_stream;

  localparam int T  = 8;
  localparam int Q  = 64;
  localparam int CW = 6;
  localparam int D  = 1;
  localparam int NA = D + 1;
  localparam int NR = 2 * D + 1;
  localparam int IW = $clog2(NR);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_entry;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_entry;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  homomorphic_multiply_stream #(
    .PLAINTEXT_MODULUS (T),
    .PLAINTEXT_WIDTH   (3),
    .CIPHERTEXT_MODULUS(Q),
    .CIPHERTEXT_WIDTH  (CW),
    .DIMENSION         (D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_entry (in_entry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_entry(out_entry),
    .out_index(out_index),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference: result[k] = sum_{i+j=k} a[i]*b[j] mod q, then optional rescale
  task automatic model(input int a[NA], input int b[NA], output int r[NR]);
    for (int k = 0; k < NR; k++) begin
      int s = 0;
      for (int i = 0; i < NA; i++)
        for (int j = 0; j < NA; j++)
          if (i + j == k) s += a[i] * b[j];
      s = s % Q;
`ifdef HM_RESCALE_EN
      s = (s * T + Q / 2) / Q;
`endif
      r[k] = s;
    end
  endtask

  // Feeds A then B at full rate; ends on the negedge after the last B beat
  task automatic load(input int a[NA], input int b[NA]);
    for (int n = 0; n < 2 * NA; n++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL load_ready beat %0d: in_ready=%b out_valid=%b, required 1/0", n, in_ready, out_valid);
      end
      if (n > 0) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL load_busy beat %0d: busy=%b, required 1", n, busy);
        end
      end
      in_valid = 1'b1;
      in_entry = (n < NA) ? CW'(a[n]) : CW'(b[n - NA]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_entry = '0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL latency: out_valid=%b in_ready=%b one cycle after last B, required 1/0", out_valid, in_ready);
    end
  endtask

  // Drains all entries with out_ready=1 and compares against exp
  task automatic drain_check(input int exp[NR], input string name);
    out_ready = 1'b1;
    for (int k = 0; k < NR; k++) begin
      int t = 0;
      while (out_valid !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s timeout k=%0d: out_valid=%b, required 1", name, k, out_valid);
        return;
      end
      n_checks++;
      if (out_entry !== CW'(exp[k]) || out_index !== IW'(k) || out_last !== (k == NR - 1)) begin
        n_fail++;
        $display("FAIL %s k=%0d: entry=%0d index=%0d last=%b, required %0d/%0d/%b",
                 name, k, out_entry, out_index, out_last, exp[k], k, (k == NR - 1));
      end
      @(negedge clk);
    end
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_last: in_ready=%b out_valid=%b busy=%b, required 1/0/0",
               name, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_entry !== '0 ||
        out_index !== '0 || out_last !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b entry=%0d index=%0d last=%b busy=%b, required 1/0/0/0/0/0",
               in_ready, out_valid, out_entry, out_index, out_last, busy);
    end
  endtask

  task automatic test_basic();
    int a[NA], b[NA], r[NR];
    a = '{26, 20};
    b = '{3, 0};
    model(a, b, r);
    load(a, b);
    drain_check(r, "basic");
  endtask

  task automatic test_wrap();
    int a[NA], b[NA], r[NR];
    a = '{63, 63};
    b = '{63, 63};
    model(a, b, r);
    load(a, b);
    drain_check(r, "wrap");
  endtask

  task automatic test_random();
    int a[NA], b[NA], r[NR];
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NA; i++) begin
        a[i] = int'($urandom_range(Q - 1, 0));
        b[i] = int'($urandom_range(Q - 1, 0));
      end
      model(a, b, r);
      load(a, b);
      // Input beats offered during DRAIN must be ignored
      in_valid = 1'b1;
      in_entry = CW'($urandom);
      drain_check(r, "random");
      in_valid = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int a[NA], b[NA], r[NR];
    a = '{26, 20};
    b = '{3, 0};
    model(a, b, r);
    load(a, b);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_entry !== CW'(r[1]) || out_index !== IW'(1) || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure hold %0d: valid=%b entry=%0d index=%0d in_ready=%b, required 1/%0d/1/0",
                 c, out_valid, out_entry, out_index, in_ready, r[1]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 1; k < NR; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_entry !== CW'(r[k]) || out_index !== IW'(k) || out_last !== (k == NR - 1)) begin
        n_fail++;
        $display("FAIL backpressure resume k=%0d: valid=%b entry=%0d index=%0d last=%b, required 1/%0d/%0d/%b",
                 k, out_valid, out_entry, out_index, out_last, r[k], k, (k == NR - 1));
      end
      @(negedge clk);
    end
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure end: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_clear();
    int a[NA], b[NA], r[NR];
    a = '{26, 20};
    b = '{3, 0};
    model(a, b, r);
    // A entries plus the first B beat, then clear while another beat is offered
    for (int n = 0; n < NA + 1; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_entry = CW'(37 + n);
    end
    @(negedge clk);
    clear    = 1'b1;
    in_entry = CW'(55);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: in_ready=%b out_valid=%b busy=%b, required 1/0/0", in_ready, out_valid, busy);
    end
    load(a, b);
    drain_check(r, "after_clear");
  endtask

  task automatic test_reset_mid_drain();
    int a[NA], b[NA], r[NR];
    a = '{26, 20};
    b = '{3, 0};
    model(a, b, r);
    load(a, b);
    out_ready = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_entry !== '0 ||
        out_index !== '0 || out_last !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b entry=%0d index=%0d last=%b busy=%b, required 1/0/0/0/0/0",
               in_ready, out_valid, out_entry, out_index, out_last, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load(a, b);
    drain_check(r, "after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_entry  = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_backpressure();
    test_clear();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/homomorphic_multiply_stream.md
# homomorphic_multiply_stream

Streaming, parametrised successor to the homomorphic multiplier. It accepts two ciphertexts of DIMENSION+1 entries each over a valid/ready input port and computes their modular convolution, result[k] = Σ_{i+j=k} A[i]·B[j] mod CIPHERTEXT_MODULUS. It then drains the 2·DIMENSION+1 result entries over a valid/ready output port with backpressure. It sits between the encrypt datapath and downstream decrypt/relinearisation logic.

## Interface
- PLAINTEXT_MODULUS, 8, plaintext modulus t (power of two)
- PLAINTEXT_WIDTH, 3, log2(t)
- CIPHERTEXT_MODULUS, 64, ciphertext modulus q (power of two)
- CIPHERTEXT_WIDTH, 6, log2(q)
- DIMENSION, 1, ciphertext has DIMENSION+1 entries; result has 2·DIMENSION+1
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort: discard operands and accumulators
- in_valid  in  1  in_entry valid
- in_ready  out  1  block can accept in_entry
- in_entry  in  CIPHERTEXT_WIDTH  ciphertext entry (A entries first, then B entries, each in index order 0..DIMENSION)
- out_valid  out  1  out_entry valid
- out_ready  in  1  consumer accepts out_entry
- out_entry  out  CIPHERTEXT_WIDTH  result entry
- out_index  out  $clog2(2·DIMENSION+1)  index k of out_entry
- out_last  out  1  high with entry k = 2·DIMENSION
- busy  out  1  high unless in LOAD_A with no A entry held

## Operation
- States: LOAD_A, LOAD_B, DRAIN.
- LOAD_A: in_ready=1. Each accepted beat (in_valid & in_ready) writes A[cnt] and increments cnt. When the beat at cnt=DIMENSION is accepted, cnt←0 and the state moves to LOAD_B.
- LOAD_B: in_ready=1. An accepted beat b_j updates every i in 0..DIMENSION in parallel: acc[i+j] ← acc[i+j] + A[i]·b_j. After the beat at j=DIMENSION, the state moves to DRAIN with k←0.
- DRAIN: in_ready=0. out_valid=1 and out_entry=f(acc[k]). Each accepted output beat (out_valid & out_ready) increments k. Accepting k=2·DIMENSION clears all acc, A and counters and returns the state to LOAD_A.
- Arithmetic: all products and sums are truncated to CIPHERTEXT_WIDTH bits, which is exact mod q. Operands are unsigned. acc has 2·DIMENSION+1 entries, each CIPHERTEXT_WIDTH wide.
- f(x) = x unless HM_RESCALE_EN is defined (see Configuration).
- clear has priority over every handshake in the same cycle. It forces LOAD_A, zeroes A, acc and counters, and drops out_valid on the next cycle; any beat offered in that cycle is dropped.
- in_valid while in_ready=0 is ignored. out_entry, out_index and out_last stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: state=LOAD_A, in_ready=1, out_valid=0, out_entry=0, out_index=0, out_last=0, busy=0, all acc/A=0.
- Reset is asynchronous at assertion. The first accepted beat is on the first rising edge after rst_n rises. Reset asserted mid-operation aborts the operation exactly as clear does.
- Input: one beat per cycle, zero bubbles required. A full load takes 2·(DIMENSION+1) cycles at in_valid=1.
- Latency: out_valid rises on the cycle after the final B beat is accepted, because the accumulate is registered.
- Drain: one entry per cycle while out_ready=1. in_ready returns to 1 on the cycle after out_last is accepted.
- Throughput at full rate: 2·(DIMENSION+1) + 2·DIMENSION+1 cycles per multiply.

## Configuration
- HM_RESCALE_EN
  - Undefined: f(x) = x, the raw tensor entry mod q.
  - Defined: f(x) = ((x·PLAINTEXT_MODULUS) + CIPHERTEXT_MODULUS/2) >> CIPHERTEXT_WIDTH, the BFV round(t·x/q). The intermediate sum is computed at CIPHERTEXT_WIDTH+PLAINTEXT_WIDTH+1 bits and the result is zero-extended to CIPHERTEXT_WIDTH.
  - Cycle timing is identical in both configurations.

## Test plan
- Defaults, A=[26,20], B=[3,0], out_ready=1 -> outputs 14 (k=0), 60 (k=1), 0 (k=2, out_last=1). out_valid rises 1 cycle after the last B beat.
- Same stimulus with HM_RESCALE_EN defined -> outputs 2, 8, 0.
- DIMENSION=2, A=[1,2,3], B=[4,5,6] -> outputs 4, 13, 28, 27, 18. out_last is set only on 18.
- Wrap: A=[63,63], B=[63,63] -> outputs 1, 2, 1.
- Backpressure: hold out_ready=0 for 5 cycles at k=1 -> out_entry=60 and out_index=1 are held stable, in_ready=0 throughout. The drain resumes in order once out_ready=1, then in_ready=1 the cycle after out_last is accepted.
- Abort: assert clear after the first B beat, then reload A=[26,20], B=[3,0] -> outputs 14, 60, 0 with no residue. Repeat the abort with rst_n pulsed low mid-DRAIN -> all outputs return to their reset values immediately.
